// File: rtl/io_bus_controller.sv
// IO-window controller for the 65C02: decodes peripheral channels, inserts programmable
// wait states and ready handshakes with timeout, and aggregates peripheral interrupts.
module io_bus_controller #(
  parameter int          NUM_CH      = 4,
  parameter logic [15:0] IO_BASE     = 16'hF000,
  parameter int          SPAN_LOG2   = 4,
  parameter logic [15:0] CTRL_OFFSET = 16'h0F00,
  parameter logic [3:0]  WAIT_RST    = 4'd2,
  parameter int          TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       address,
  input  logic [7:0]        di,
  input  logic              we,
  input  logic              io_sel,
  output logic              rdy,
  output logic [7:0]        dout,
  output logic              do_oe,
  output logic [NUM_CH-1:0] ch_sel,
  output logic [NUM_CH-1:0] ch_wr_stb,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_irq,
  output logic              irq
);

  localparam int          CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0] PAGE_BASE = IO_BASE + CTRL_OFFSET;
  localparam logic [15:0] NUM_CH_W  = 16'(NUM_CH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt;
  logic [TW-1:0]     tmo;
  logic [CW-1:0]     cur;
  logic [3:0]        wait_cfg [NUM_CH];
  logic [NUM_CH-1:0] pend, mask, irq_prev, w1c;
  logic              err, irq_q;
  logic [2:0]        err_ch;
  logic [15:0]       rel, idx_wide;
  logic [CW-1:0]     idx;
  logic [3:0]        off;
  logic              page_hit, ch_hit, page_wr;
  logic              rdy_c, timeout_c;
  logic [NUM_CH-1:0] sel_c, stb_c;
  logic [7:0]        rd_c;
  logic              unused_di;

  assign off       = address[3:0];
  assign rel       = address - IO_BASE;
  assign idx_wide  = rel >> SPAN_LOG2;
  assign idx       = idx_wide[CW-1:0];
  assign page_hit  = io_sel && (address[15:4] == PAGE_BASE[15:4]);
  assign ch_hit    = io_sel && !page_hit && (address >= IO_BASE) && (idx_wide < NUM_CH_W);
  assign page_wr   = page_hit && we;
  assign w1c       = (page_wr && off == 4'd0) ? di[NUM_CH-1:0] : {NUM_CH{1'b0}};
  assign unused_di = ^di;

  // Register page read mux
  always_comb begin
    rd_c = 8'h00;
    case (off)
      4'd0: rd_c = 8'(pend);
      4'd1: rd_c = 8'(mask);
      4'd2: rd_c = 8'(ch_irq);
      4'd3: rd_c = {1'b0, err_ch, 3'b000, err};
      default: begin
        for (int c = 0; c < NUM_CH; c++) begin
          rd_c = (off == 4'(c + 4)) ? {4'h0, wait_cfg[c]} : rd_c;
        end
      end
    endcase
  end

  // Access FSM: next state, stall and per-channel select/strobe
  always_comb begin
    state_next = state;
    rdy_c      = 1'b1;
    sel_c      = {NUM_CH{1'b0}};
    stb_c      = {NUM_CH{1'b0}};
    timeout_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ch_hit) begin
          sel_c[idx] = 1'b1;
          if (wait_cfg[idx] == 4'd0 && ch_ready[idx]) begin
            stb_c[idx] = we;
          end else begin
            rdy_c      = 1'b0;
            state_next = S_WAIT;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        rdy_c      = 1'b0;
        sel_c[cur] = 1'b1;
        if (cnt == 4'd0 && ch_ready[cur]) begin
          state_next = S_DONE;
        end else if (tmo == TMO_LAST) begin
          state_next = S_DONE;
          timeout_c  = 1'b1;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_DONE: begin
        sel_c[cur] = 1'b1;
        stb_c[cur] = we;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Reset forces the bus-facing outputs idle even while the address still hits a channel
  assign rdy       = reset ? rdy_c : 1'b1;
  assign ch_sel    = reset ? sel_c : {NUM_CH{1'b0}};
  assign ch_wr_stb = reset ? stb_c : {NUM_CH{1'b0}};
  assign do_oe     = reset && page_hit && !we;
  assign dout      = do_oe ? rd_c : 8'h00;
  assign irq       = irq_q;

  // State register plus wait/timeout counters; cnt is preloaded one short because the
  // IDLE cycle that starts the stall already counts as the first wait state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      tmo   <= {TW{1'b0}};
      cur   <= {CW{1'b0}};
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          cnt <= (wait_cfg[idx] == 4'd0) ? 4'd0 : wait_cfg[idx] - 4'd1;
          tmo <= {TW{1'b0}};
          cur <= idx;
        end
        S_WAIT: begin
          cnt <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
          tmo <= (tmo == TMO_LAST) ? tmo : tmo + TW'(1);
        end
        default: begin
          cnt <= cnt;
          tmo <= tmo;
        end
      endcase
    end
  end

  // Control/status registers and interrupt aggregation; an edge set beats a same-cycle W1C
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) wait_cfg[c] <= WAIT_RST;
      mask     <= {NUM_CH{1'b0}};
      pend     <= {NUM_CH{1'b0}};
      irq_prev <= {NUM_CH{1'b0}};
      err      <= 1'b0;
      err_ch   <= 3'd0;
      irq_q    <= 1'b0;
    end else begin
      irq_prev <= ch_irq;
      irq_q    <= |(pend & mask);
      pend     <= (pend & ~w1c) | (ch_irq & ~irq_prev);
      if (page_wr && off == 4'd1) mask <= di[NUM_CH-1:0];
      else                        mask <= mask;
      if (timeout_c) begin
        err    <= 1'b1;
        err_ch <= 3'(cur);
      end else if (page_wr && off == 4'd3 && di[0]) begin
        err    <= 1'b0;
        err_ch <= 3'd0;
      end else begin
        err    <= err;
        err_ch <= err_ch;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (page_wr && off == 4'(c + 4)) wait_cfg[c] <= di[3:0];
        else                             wait_cfg[c] <= wait_cfg[c];
      end
    end
  end

endmodule

// File: tb/tb_io_bus_controller.sv
// Scoreboard bench for io_bus_controller: the driver pushes expected completions computed from
// an abstract register/latency model; a negedge monitor pops and compares on every completion.
module tb_io_bus_controller;

  logic        clk = 1'b0;
  logic        reset, we, io_sel, rdy, do_oe, irq;
  logic [15:0] address;
  logic [7:0]  di, dout;
  logic [3:0]  ch_sel, ch_wr_stb, ch_ready, ch_irq;

  always #5 clk = ~clk;

  io_bus_controller dut (
    .clk(clk), .reset(reset), .address(address), .di(di), .we(we), .io_sel(io_sel),
    .rdy(rdy), .dout(dout), .do_oe(do_oe), .ch_sel(ch_sel), .ch_wr_stb(ch_wr_stb),
    .ch_ready(ch_ready), .ch_irq(ch_irq), .irq(irq)
  );

  typedef struct {
    int         stall;
    logic [3:0] sel;
    logic [3:0] stb;
    logic       oe;
    logic [7:0] data;
    logic       chk_irq;
    logic       irq;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  logic [3:0] wait_m [4];
  logic [3:0] pend_m, mask_m, prev_m;
  logic       err_m, irq_m;
  logic [2:0] errch_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [3:0] off);
    case (off)
      4'd0: return {4'h0, pend_m};
      4'd1: return {4'h0, mask_m};
      4'd2: return {4'h0, ch_irq};
      4'd3: return {1'b0, errch_m, 3'b000, err_m};
      4'd4: return {4'h0, wait_m[0]};
      4'd5: return {4'h0, wait_m[1]};
      4'd6: return {4'h0, wait_m[2]};
      4'd7: return {4'h0, wait_m[3]};
      default: return 8'h00;
    endcase
  endfunction

  // One clock: update the register model from the inputs seen at this edge.
  task automatic tick();
    logic       pw;
    logic [3:0] off, w1c, rise;
    logic       irq_next;
    off = address[3:0];
    pw  = io_sel && we && (address[15:4] == 12'hFF0);
    @(posedge clk);
    if (!reset) begin
      for (int c = 0; c < 4; c++) wait_m[c] = 4'd2;
      pend_m = 4'h0; mask_m = 4'h0; prev_m = 4'h0;
      err_m = 1'b0; errch_m = 3'd0; irq_m = 1'b0;
    end else begin
      irq_next = |(pend_m & mask_m);
      rise     = ch_irq & ~prev_m;
      w1c      = (pw && off == 4'd0) ? di[3:0] : 4'h0;
      if (pw && off == 4'd1) mask_m = di[3:0];
      if (pw && off == 4'd3 && di[0]) begin err_m = 1'b0; errch_m = 3'd0; end
      if (pw && off >= 4'd4 && off <= 4'd7) wait_m[off - 4'd4] = di[3:0];
      pend_m = (pend_m & ~w1c) | rise;
      prev_m = ch_irq;
      irq_m  = irq_next;
    end
    #1;
  endtask

  // One CPU access; dly = cycles the target channel keeps ch_ready low from access start.
  task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d, input int dly);
    exp_t e;
    bit   is_page, is_ch, err_exp, done;
    int   c, m, t;
    is_page = (a[15:4] == 12'hFF0);
    is_ch   = !is_page && (a >= 16'hF000) && (a < 16'hF040);
    c       = is_ch ? int'((a - 16'hF000) >> 4) : 0;
    e       = '{stall: 0, sel: 4'h0, stb: 4'h0, oe: 1'b0, data: 8'h00, chk_irq: 1'b0, irq: 1'b0};
    err_exp = 1'b0;
    if (is_page) begin
      e.oe      = !w;
      e.data    = w ? 8'h00 : model_read(a[3:0]);
      e.chk_irq = 1'b1;
      e.irq     = irq_m;
    end else if (is_ch) begin
      e.sel = 4'(1 << c);
      e.stb = w ? 4'(1 << c) : 4'h0;
      if (!(wait_m[c] == 4'd0 && dly == 0)) begin
        m = (int'(wait_m[c]) > 1) ? int'(wait_m[c]) : 1;
        if (dly > m) m = dly;
        e.stall = 1 + ((m > 64) ? 64 : m);
        err_exp = (m > 64);
      end
    end
    address  = a; we = w; di = d; io_sel = 1'b1;
    ch_ready = 4'($urandom);
    if (is_ch) ch_ready[c] = (dly == 0);
    q.push_back(e);
    t = 0;
    forever begin
      @(negedge clk);
      done = rdy;
      tick();
      if (done) break;
      t++;
      if (is_ch) ch_ready[c] = (t >= dly);
      if (t > 200) begin
        chk("access_bound", 32'(t), 32'd200);
        break;
      end
    end
    if (err_exp) begin err_m = 1'b1; errch_m = 3'(c); end
    io_sel = 1'b0; we = 1'b0;
  endtask

  // Monitor: count stall cycles and compare each completion against the scoreboard.
  initial begin
    int   mon_stall;
    logic sel_bad, stb_bad;
    exp_t e;
    mon_stall = 0; sel_bad = 1'b0; stb_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        mon_stall = 0; sel_bad = 1'b0; stb_bad = 1'b0;
      end else if (io_sel) begin
        if (!rdy) begin
          mon_stall++;
          if (ch_wr_stb != 4'h0) stb_bad = 1'b1;
          if (q.size() > 0 && ch_sel != q[0].sel) sel_bad = 1'b1;
        end else if (q.size() == 0) begin
          chk("unexpected_completion", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("stall_cycles", 32'(mon_stall), 32'(e.stall));
          chk("ch_sel", 32'(ch_sel), 32'(e.sel));
          chk("wr_stb", 32'(ch_wr_stb), 32'(e.stb));
          chk("sel_held", 32'(sel_bad), 32'd0);
          chk("stb_in_stall", 32'(stb_bad), 32'd0);
          chk("do_oe", 32'(do_oe), 32'(e.oe));
          chk("do_data", 32'(dout), 32'(e.data));
          if (e.chk_irq) chk("irq", 32'(irq), 32'(e.irq));
          mon_stall = 0; sel_bad = 1'b0; stb_bad = 1'b0;
        end
      end else begin
        chk("idle_strobe", 32'(ch_wr_stb), 32'd0);
        mon_stall = 0; sel_bad = 1'b0; stb_bad = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         r, c, dly;
    logic [3:0] off;
    reset = 1'b0; io_sel = 1'b0; we = 1'b0; di = 8'h00; address = 16'h0000;
    ch_ready = 4'h0; ch_irq = 4'h0;
    tick(); tick();
    chk("reset_rdy", 32'(rdy), 32'd1);
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_oe", 32'(do_oe), 32'd0);
    chk("reset_sel", 32'(ch_sel), 32'd0);
    reset = 1'b1;
    tick();

    // reset values of the register page
    for (int i = 0; i < 4; i++) access(16'hFF04 + 16'(i), 1'b0, 8'h00, 0);
    access(16'hFF01, 1'b0, 8'h00, 0);
    access(16'hFF03, 1'b0, 8'h00, 0);

    // channel address with io_sel low: no select, no stall
    address = 16'hF010; io_sel = 1'b0; we = 1'b1;
    #1;
    chk("nosel_rdy", 32'(rdy), 32'd1);
    chk("nosel_chsel", 32'(ch_sel), 32'd0);
    tick(); we = 1'b0;

    // wait states, ready handshake, timeout
    access(16'hFF05, 1'b1, 8'h03, 0);
    access(16'hF010, 1'b0, 8'h00, 0);
    access(16'hFF06, 1'b1, 8'h00, 0);
    access(16'hF020, 1'b1, 8'hA5, 5);
    tick(); tick();
    access(16'hF030, 1'b0, 8'h00, 1000);
    access(16'hFF03, 1'b0, 8'h00, 0);
    access(16'hFF03, 1'b1, 8'h01, 0);
    access(16'hFF03, 1'b0, 8'h00, 0);
    access(16'hF0A0, 1'b1, 8'h11, 0);

    // interrupts: pending edge capture, mask, W1C
    access(16'hFF01, 1'b1, 8'h05, 0);
    ch_irq = 4'b0001; tick();
    ch_irq = 4'b0010; tick(); tick();
    access(16'hFF00, 1'b0, 8'h00, 0);
    access(16'hFF00, 1'b1, 8'h01, 0);
    tick(); tick();
    chk("irq_after_w1c", 32'(irq), 32'(irq_m));
    access(16'hFF00, 1'b0, 8'h00, 0);
    ch_irq = 4'b0011;
    access(16'hFF00, 1'b1, 8'h01, 0);
    access(16'hFF00, 1'b0, 8'h00, 0);
    access(16'hFF02, 1'b0, 8'h00, 0);

    // reset in the middle of a stall aborts without a strobe
    ch_irq = 4'h0;
    access(16'hFF05, 1'b1, 8'h03, 0);
    address = 16'hF010; we = 1'b1; io_sel = 1'b1; ch_ready = 4'hF;
    tick(); tick();
    chk("abort_stalled", 32'(rdy), 32'd0);
    reset = 1'b0;
    tick();
    chk("abort_rdy", 32'(rdy), 32'd1);
    chk("abort_stb", 32'(ch_wr_stb), 32'd0);
    chk("abort_sel", 32'(ch_sel), 32'd0);
    reset = 1'b1; io_sel = 1'b0; we = 1'b0;
    tick();
    access(16'hFF05, 1'b0, 8'h00, 0);

    // randomized mix
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        c   = int'($urandom_range(0, 3));
        dly = ($urandom_range(0, 9) == 0) ? 70 : int'($urandom_range(0, 8));
        access(16'hF000 + 16'(c * 16) + 16'($urandom_range(0, 15)), 1'($urandom), 8'($urandom), dly);
      end else if (r <= 5) begin
        off = 4'($urandom_range(0, 9));
        if (off >= 4'd4) access(16'hFF00 + 16'(off), 1'b1, {4'($urandom), 4'($urandom_range(0, 5))}, 0);
        else             access(16'hFF00 + 16'(off), 1'b1, 8'($urandom), 0);
      end else if (r <= 7) begin
        access(16'hFF00 + 16'($urandom_range(0, 15)), 1'b0, 8'h00, 0);
      end else if (r == 8) begin
        access(16'($urandom_range(16'hF040, 16'hFEFF)), 1'($urandom), 8'($urandom), 0);
      end else begin
        ch_irq = 4'($urandom);
        tick();
      end
    end
    tick();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
